gpu_cmd_queue: RTL and testbench

GPU_CMD_QUEUE -- requirements
Module: gpu_cmd_queue

---
 rtl/gpu_cmd_queue.sv | 175 +++++++++++++++++
 tb/tb_gpu_cmd_queue.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_cmd_queue.sv
// Purpose: command FIFO feeding a single-outstanding issuer that handshakes instructions to the graphic card.
// Latency: a word pushed into an empty queue with the card idle strobes GpuExecute one cycle after its push edge.
// Backpressure: CmdReady drops while DEPTH words are queued; a push while full is dropped and sets sticky Overflow.
module gpu_cmd_queue #(
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int CMD_WIDTH = 25,
    parameter int TIMEOUT   = 262143
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 CmdValid,
    input  logic [CMD_WIDTH-1:0] CmdData,
    output logic                 CmdReady,
    input  logic                 Flush,
    input  logic                 GpuReady,
    output logic                 GpuExecute,
    output logic [CMD_WIDTH-1:0] GpuInstruction,
    input  logic [CMD_WIDTH-1:0] GpuDataOutput,
    output logic                 ResultValid,
    output logic [CMD_WIDTH-1:0] ResultData,
    output logic [AW:0]          Level,
    output logic                 Busy,
    output logic                 Overflow,
    output logic                 Timeout
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]      LVL_ONE  = 1;
    localparam logic [AW:0]      LVL_FULL = DEPTH;
    localparam logic [AW-1:0]    PTR_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT - 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH} state_t;

    state_t                 state, state_nxt;
    logic [CMD_WIDTH-1:0]   mem [DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [AW:0]            level;
    logic                   push_en, pop_en, tmo_hit, res_cap;
    logic [1:0]             hi_cnt;
    logic [CNT_W-1:0]       wait_cnt;
    logic [CMD_WIDTH-1:0]   gpu_instr_q;
    logic                   result_vld_q;
    logic [CMD_WIDTH-1:0]   result_dat_q;
    logic                   overflow_q, timeout_q;

    // Flush wins over a push in the same cycle, so the word is not written either
    assign CmdReady = (level != LVL_FULL);
    assign push_en  = CmdValid && CmdReady && !Flush;
    assign res_cap  = (state == WAIT_HIGH) && GpuReady;

    assign GpuInstruction = gpu_instr_q;
    assign ResultValid    = result_vld_q;
    assign ResultData     = result_dat_q;
    assign Level          = level;
    assign Overflow       = overflow_q;
    assign Timeout        = timeout_q;

    // Issuer state register
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Issuer next state; tmo_hit marks an abandoned command on the way back to IDLE
    always_comb begin
        state_nxt = state;
        tmo_hit   = 1'b0;
        case (state)
            IDLE:      if (pop_en) state_nxt = ISSUE;
            ISSUE:     state_nxt = WAIT_LOW;
            WAIT_LOW: begin
                if (!GpuReady) begin
                    state_nxt = WAIT_HIGH;
                end else if (hi_cnt == 2'd2) begin
                    state_nxt = IDLE;
                    tmo_hit   = 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (GpuReady) begin
                    state_nxt = IDLE;
                end else if (wait_cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    tmo_hit   = 1'b1;
                end
            end
            default:   state_nxt = IDLE;
        endcase
    end

    // Issuer outputs; a pop is suppressed by Flush so the discarded head is never issued
    always_comb begin
        GpuExecute = 1'b0;
        Busy       = 1'b1;
        pop_en     = 1'b0;
        case (state)
            IDLE: begin
                Busy   = 1'b0;
                pop_en = (level != '0) && GpuReady && !Flush;
            end
            ISSUE:   GpuExecute = 1'b1;
            default: ;
        endcase
    end

    // Ready-still-high counter in WAIT_LOW and elapsed-cycle counter in WAIT_HIGH, both cleared on entry
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            hi_cnt   <= 2'd0;
            wait_cnt <= '0;
        end else begin
            hi_cnt   <= (state == WAIT_LOW && GpuReady) ? hi_cnt + 2'd1 : 2'd0;
            wait_cnt <= (state == WAIT_HIGH) ? wait_cnt + CNT_ONE : '0;
        end
    end

    // FIFO storage; contents need no reset since Level gates every read
    always_ff @(posedge Clk) begin
        if (push_en) mem[wr_ptr] <= CmdData;
    end

    // FIFO pointers and exact occupancy
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (Flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_en)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_en, pop_en})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    // Instruction register holds the last popped word until the next pop
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)        gpu_instr_q <= '0;
        else if (pop_en) gpu_instr_q <= mem[rd_ptr];
    end

    // Result capture when the card raises Ready again; pulse lasts one cycle
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            result_vld_q <= 1'b0;
            result_dat_q <= '0;
        end else begin
            result_vld_q <= res_cap;
            if (res_cap) result_dat_q <= GpuDataOutput;
        end
    end

    // Sticky error flags, cleared only by Flush or reset
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else if (Flush) begin
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            if (CmdValid && !CmdReady) overflow_q <= 1'b1;
            if (tmo_hit)               timeout_q  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_gpu_cmd_queue.sv
// Bench for gpu_cmd_queue: card model, queue-level reference model with per-cycle compare, directed scenarios.
// Card: after a strobe, Ready low for 1 sampled edge (CLEAR: clear_low edges), then returns {5'b0, operand}.
// Reference: queue of accepted words, expected outcome per issued command, sticky flag model.
module tb_gpu_cmd_queue;
    localparam int DEPTH_P = 16;
    localparam int AW_P    = 4;
    localparam int W_P     = 25;
    localparam int TMO_P   = 100;

    logic              Clk = 1'b0;
    logic              Rst = 1'b1;
    logic              CmdValid;
    logic [W_P-1:0]    CmdData;
    logic              CmdReady;
    logic              Flush;
    logic              GpuReady;
    logic              GpuExecute;
    logic [W_P-1:0]    GpuInstruction;
    logic [W_P-1:0]    GpuDataOutput;
    logic              ResultValid;
    logic [W_P-1:0]    ResultData;
    logic [AW_P:0]     Level;
    logic              Busy;
    logic              Overflow;
    logic              Timeout;

    gpu_cmd_queue #(.DEPTH(DEPTH_P), .AW(AW_P), .CMD_WIDTH(W_P), .TIMEOUT(TMO_P)) dut (
        .Clk(Clk), .Rst(Rst), .CmdValid(CmdValid), .CmdData(CmdData), .CmdReady(CmdReady),
        .Flush(Flush), .GpuReady(GpuReady), .GpuExecute(GpuExecute), .GpuInstruction(GpuInstruction),
        .GpuDataOutput(GpuDataOutput), .ResultValid(ResultValid), .ResultData(ResultData),
        .Level(Level), .Busy(Busy), .Overflow(Overflow), .Timeout(Timeout)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- card model ----------------
    bit             card_hold  = 1'b0;
    bit             card_stuck = 1'b0;
    int             clear_low  = 60;
    int             card_cnt   = 0;
    logic [W_P-1:0] card_word  = '0;

    // Card reacts on the falling edge so its Ready is stable at every rising edge
    always @(negedge Clk) begin
        if (card_hold) begin
            GpuReady = 1'b0;
            card_cnt = 0;
        end else if (card_stuck) begin
            GpuReady = 1'b1;
        end else if (GpuExecute) begin
            card_word = GpuInstruction;
            GpuReady  = 1'b0;
            card_cnt  = (GpuInstruction[23:20] == 4'h4) ? clear_low : 1;
        end else if (card_cnt > 0) begin
            card_cnt--;
        end else if (!GpuReady) begin
            GpuReady      = 1'b1;
            GpuDataOutput = {5'b0, card_word[19:0]};
        end
    end

    // ---------------- reference model and per-cycle compare ----------------
    logic [W_P-1:0] mq[$];
    bit             inflight, inflight_tmo, m_ovf, m_tmo, have_exec, full_before, done_now;
    logic [W_P-1:0] inflight_res, popped, last_result;
    int             cyc = 0, exec_count = 0, result_count = 0, last_exec_cyc = 0, last_done_cyc = 0;

    always @(posedge Clk) begin
        #1;
        cyc++;
        if (!Rst) begin
            mq.delete();
            inflight  = 1'b0;
            m_ovf     = 1'b0;
            m_tmo     = 1'b0;
            have_exec = 1'b0;
        end else begin
            full_before = (mq.size() == DEPTH_P);
            done_now    = inflight && !Busy;
            chk("result_valid", ResultValid, done_now && !inflight_tmo);
            if (done_now) begin
                inflight      = 1'b0;
                last_done_cyc = cyc;
                if (inflight_tmo) m_tmo = 1'b1;
                else begin
                    chk("result_data", ResultData, inflight_res);
                    result_count++;
                    last_result = ResultData;
                end
            end
            if (GpuExecute) begin
                exec_count++;
                if (have_exec) chk("strobe_gap_ge4", (cyc - last_exec_cyc) >= 4, 1);
                last_exec_cyc = cyc;
                have_exec     = 1'b1;
                if (mq.size() == 0) begin
                    chk("pop_from_empty", 1, 0);
                    popped = GpuInstruction;
                end else begin
                    popped = mq.pop_front();
                    chk("issue_order", GpuInstruction, popped);
                end
                inflight     = 1'b1;
                inflight_tmo = card_stuck || (popped[23:20] == 4'h4 && clear_low - 1 >= TMO_P);
                inflight_res = {5'b0, popped[19:0]};
            end
            if (Flush) begin
                mq.delete();
                m_ovf = 1'b0;
                m_tmo = 1'b0;
            end else if (CmdValid) begin
                if (!full_before) mq.push_back(CmdData);
                else m_ovf = 1'b1;
            end
            chk("level", Level, mq.size());
            chk("cmd_ready", CmdReady, mq.size() != DEPTH_P);
            chk("overflow", Overflow, m_ovf);
            chk("busy", Busy, inflight);
            if (!Busy) chk("timeout", Timeout, m_tmo);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic push(input logic [W_P-1:0] w);
        CmdValid = 1'b1;
        CmdData  = w;
        @(negedge Clk);
        CmdValid = 1'b0;
    endtask

    task automatic wait_exec(input int target, input int limit, input string name);
        int k = 0;
        while (exec_count < target && k < limit) begin
            @(negedge Clk);
            k++;
        end
        if (exec_count < target) begin
            n_checks++;
            $display("FAIL %s: no strobe within %0d cycles, strobes %0d required %0d", name, limit, exec_count, target);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_level"},   Level, 0);
        chk({tag, "_ready"},   CmdReady, 1);
        chk({tag, "_exec"},    GpuExecute, 0);
        chk({tag, "_instr"},   GpuInstruction, 0);
        chk({tag, "_rvalid"},  ResultValid, 0);
        chk({tag, "_rdata"},   ResultData, 0);
        chk({tag, "_busy"},    Busy, 0);
        chk({tag, "_ovf"},     Overflow, 0);
        chk({tag, "_tmo"},     Timeout, 0);
    endtask

    int base_e, base_r, push_c;

    initial begin
        CmdValid = 1'b0; CmdData = '0; Flush = 1'b0; GpuReady = 1'b1; GpuDataOutput = '0;
        #1 Rst = 1'b0;
        #2 chk_reset_outputs("por");
        tick(3);
        Rst = 1'b1;
        tick(2);

        // Single ECHO: one strobe one cycle after the push edge, operand echoed back
        base_e = exec_count; base_r = result_count;
        CmdValid = 1'b1; CmdData = 25'h112345;
        @(negedge Clk);
        CmdValid = 1'b0;
        push_c = cyc;
        @(negedge Clk);
        chk("echo_latency", last_exec_cyc - push_c, 1);
        chk("echo_exec", GpuExecute, 1);
        chk("echo_instr", GpuInstruction, 25'h112345);
        tick(6);
        chk("echo_results", result_count - base_r, 1);
        chk("echo_rdata", last_result, 25'h012345);
        chk("echo_level", Level, 0);
        chk("echo_turnaround", last_done_cyc - last_exec_cyc, 3);
        chk("echo_strobes", exec_count - base_e, 1);

        // Fill with card busy, overflow on the 17th, then drain in order
        card_hold = 1'b1;
        tick(2);
        base_e = exec_count; base_r = result_count;
        for (int i = 0; i < 17; i++) begin
            CmdValid = 1'b1;
            CmdData  = W_P'(32'h100000 | (i * 32'h1011));
            @(negedge Clk);
        end
        CmdValid = 1'b0;
        chk("fill_level", Level, 16);
        chk("fill_ready", CmdReady, 0);
        chk("fill_ovf", Overflow, 1);
        chk("fill_no_issue", exec_count - base_e, 0);
        card_hold = 1'b0;
        wait_exec(base_e + 16, 200, "drain");
        tick(6);
        chk("drain_strobes", exec_count - base_e, 16);
        chk("drain_results", result_count - base_r, 16);
        chk("drain_last", last_result, 25'h00F0FF);
        chk("drain_level", Level, 0);

        // Long CLEAR within the timeout window
        clear_low = 60;
        tick(1);
        base_e = exec_count; base_r = result_count;
        push(25'h400000);
        wait_exec(base_e + 1, 10, "clear_ok");
        tick(70);
        chk("clear_results", result_count - base_r, 1);
        chk("clear_rdata", last_result, 0);
        chk("clear_no_tmo", Timeout, 0);
        chk("clear_turnaround", last_done_cyc - last_exec_cyc, 62);

        // CLEAR longer than the timeout, followed by an ECHO that must still issue
        clear_low = 150;
        tick(1);
        base_e = exec_count; base_r = result_count;
        push(25'h400000);
        push(25'h1ABCDE);
        wait_exec(base_e + 1, 10, "clear_tmo");
        tick(110);
        chk("tmo_flag", Timeout, 1);
        chk("tmo_idle", Busy, 0);
        chk("tmo_turnaround", last_done_cyc - last_exec_cyc, 102);
        chk("tmo_no_result", result_count - base_r, 0);
        chk("tmo_level", Level, 1);
        wait_exec(base_e + 2, 100, "after_tmo");
        tick(6);
        chk("after_tmo_results", result_count - base_r, 1);
        chk("after_tmo_rdata", last_result, 25'h0ABCDE);

        // Flush clears sticky flags; then a card whose Ready never drops
        Flush = 1'b1;
        @(negedge Clk);
        Flush = 1'b0;
        chk("flush_tmo_clr", Timeout, 0);
        chk("flush_ovf_clr", Overflow, 0);
        card_stuck = 1'b1;
        tick(1);
        base_e = exec_count; base_r = result_count;
        push(25'h1000AA);
        wait_exec(base_e + 1, 10, "stuck");
        tick(8);
        chk("stuck_tmo", Timeout, 1);
        chk("stuck_idle", Busy, 0);
        chk("stuck_turnaround", last_done_cyc - last_exec_cyc, 4);
        chk("stuck_no_result", result_count - base_r, 0);
        card_stuck = 1'b0;
        tick(2);

        // Five queued, Flush during the second command
        base_e = exec_count; base_r = result_count;
        for (int i = 0; i < 5; i++) begin
            CmdValid = 1'b1;
            CmdData  = W_P'(32'h200000 | ((i + 1) * 32'h10));
            @(negedge Clk);
        end
        CmdValid = 1'b0;
        wait_exec(base_e + 2, 30, "flush_second");
        Flush = 1'b1;
        @(negedge Clk);
        Flush = 1'b0;
        chk("flush_level", Level, 0);
        tick(10);
        chk("flush_strobes", exec_count - base_e, 2);
        chk("flush_results", result_count - base_r, 2);
        chk("flush_last", last_result, 25'h000020);
        chk("flush_ovf", Overflow, 0);
        chk("flush_tmo", Timeout, 0);

        // Reset during WAIT_HIGH abandons the command
        clear_low = 60;
        tick(1);
        base_e = exec_count; base_r = result_count;
        push(25'h400000);
        wait_exec(base_e + 1, 10, "rst_mid");
        tick(5);
        chk("rst_mid_busy_before", Busy, 1);
        Rst = 1'b0;
        #1 chk_reset_outputs("rst_mid");
        @(negedge Clk);
        Rst = 1'b1;
        tick(80);
        chk("rst_no_result", result_count - base_r, 0);
        base_e = exec_count;
        push(25'h1000FF);
        wait_exec(base_e + 1, 10, "post_rst");
        tick(6);
        chk("post_rst_results", result_count - base_r, 1);
        chk("post_rst_rdata", last_result, 25'h0000FF);
        chk("post_rst_level", Level, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end
endmodule
